sound_arbiter: RTL and testbench
================================

// Module: sound_arbiter
// PURPOSE
//   Shares the single speaker tone generator between the game controller's sound sources.
//   Sources are the live colour tone (controller OUT/OUT_ENA) and four event jingles: start, win, lose, high score.
//   Latches event requests and serves them by fixed priority, sequencing each jingle's notes with tick-timed durations.
//   Sits between the controller and the tone generator; TONE/TONE_ENA feed the generator directly.
// PARAMETERS
//   TICK_DIV    1000  CLK cycles per duration tick (>=1)
//   NOTE_TICKS  8     ticks each jingle note sounds (>=1)
//   GAP_TICKS   2     silent ticks after each jingle note (0 = no gap)
// PORTS
//   CLK         in   1  system clock
//   RST_N       in   1  asynchronous active-low reset
//   COLOR_REQ   in   1  level: play colour tone (controller OUT_ENA)
//   COLOR       in   2  colour tone select (controller OUT)
//   START_REQ   in   1  level; rising edge requests start jingle (START_GAME)
//   WIN_PULSE   in   1  1-cycle win request
//   LOSE_PULSE  in   1  1-cycle lose request
//   HS_PULSE    in   1  1-cycle high-score request
//   MUTE        in   1  only when SND_MUTE_EN defined; see CONFIGURATION
//   TONE        out  3  tone code: 0-3 colour tones, 4 low buzz, 5 high chirp
//   TONE_ENA    out  1  tone generator enable
//   BUSY        out  1  jingle playing or any request pending
// BEHAVIOUR
// - Reset (async, immediate, also mid-jingle): TONE=0, TONE_ENA=0, BUSY=0.
//   Pending bits, START_REQ edge register, tick prescaler, note index and FSM are cleared to IDLE.
// - Pending bits P_LOSE, P_WIN, P_HS, P_START are set on the edge sampling their request.
//   Repeated requests of one kind merge into one bit. A request arriving during its own jingle replays it after.
// - Priority: LOSE > WIN > HS > START. A jingle is never preempted; pending work is served when it ends.
// - Jingle note lists (in order):
//     LOSE  4,4
//     WIN   0,1,2,3,5
//     HS    5,3,5
//     START 0,1,2,3
// - FSM states: IDLE, COLOR, NOTE, GAP.
//   IDLE:  any pending -> NOTE, on the edge after the bit is set.
//          Highest pending bit is cleared; note 0 loads; TONE_ENA=1.
//          Else COLOR_REQ=1 -> COLOR; TONE=COLOR, TONE_ENA=1.
//   COLOR: TONE tracks COLOR with 1-cycle latency.
//          Any pending -> NOTE (pending preempts the colour tone).
//          Else COLOR_REQ=0 -> IDLE, TONE_ENA=0 next edge.
//   NOTE:  exactly NOTE_TICKS*TICK_DIV cycles with TONE_ENA=1, TONE = current note.
//          Then GAP (GAP_TICKS>0) or next step.
//   GAP:   exactly GAP_TICKS*TICK_DIV cycles with TONE_ENA=0; TONE holds.
//   Next step: next note -> NOTE; else pending -> next jingle's NOTE.
//          Else COLOR_REQ=1 -> COLOR; else IDLE.
// - Prescaler reloads on every NOTE/GAP entry, so durations are exact and independent of request phase.
// - Latency: colour 1 cycle (COLOR_REQ -> TONE_ENA); event pulse to TONE_ENA=1 is 2 cycles.
// - BUSY = (state is NOTE or GAP) | any pending bit; registered with the FSM.
// - Duration counter width: $clog2(TICK_DIV*max(NOTE_TICKS,GAP_TICKS)+1). No wrap within a note.
// - Simultaneous HS_PULSE and LOSE_PULSE (normal on game end): LOSE plays, then HS.
// CONFIGURATION
//   SND_MUTE_EN defined: MUTE port exists.
//     MUTE=1 forces TONE_ENA=0 combinationally after the register; the FSM, timing and BUSY are unchanged.
//   SND_MUTE_EN undefined: no MUTE port; TONE_ENA is the register output.
// TESTING (TICK_DIV=4, NOTE_TICKS=2, GAP_TICKS=1 -> note 8 cycles, gap 4)
//   1. Reset with all requests active -> TONE=0, TONE_ENA=0, BUSY=0 during reset.
//      After release, start jingle serves first.
//   2. COLOR_REQ=1, COLOR=2 for 10 cycles -> TONE=2, TONE_ENA high 10 cycles, delayed 1; BUSY stays 0.
//   3. LOSE_PULSE -> TONE=4 on 8, off 4, on 8, off 4; then IDLE.
//      BUSY high 25 cycles; TONE_ENA rises 2 cycles after the pulse.
//   4. HS_PULSE and LOSE_PULSE same cycle -> notes 4,4 then 5,3,5; BUSY continuous throughout.
//   5. WIN_PULSE with COLOR_REQ held high, COLOR=1 -> colour cut, 0,1,2,3,5 plays.
//      Colour tone 1 resumes after the last gap.
//   6. SND_MUTE_EN, MUTE=1 during WIN jingle -> TONE_ENA=0; TONE steps 0,1,2,3,5 and BUSY timing identical to unmuted run.

Source files
------------

// File: rtl/sound_arbiter_if.sv
// Controller-side bundle for sound_arbiter: request inputs and tone-generator outputs.
// The mute input exists only when SND_MUTE_EN is defined.
interface sound_arbiter_if;
  // Requests carry no handshake: color_req and start_req are levels, sampled every clock
  // (start is requested on the rising edge of start_req). win/lose/hs are one-cycle pulses
  // latched into pending bits on the edge that samples them. Outputs are registered levels.
  logic       color_req;
  logic [1:0] color;
  logic       start_req;
  logic       win_pulse;
  logic       lose_pulse;
  logic       hs_pulse;
`ifdef SND_MUTE_EN
  logic       mute;
`endif
  logic [2:0] tone;
  logic       tone_ena;
  logic       busy;

  modport master (
`ifdef SND_MUTE_EN
    output mute,
`endif
    output color_req, color, start_req, win_pulse, lose_pulse, hs_pulse,
    input  tone, tone_ena, busy
  );

  modport slave (
`ifdef SND_MUTE_EN
    input  mute,
`endif
    input  color_req, color, start_req, win_pulse, lose_pulse, hs_pulse,
    output tone, tone_ena, busy
  );
endinterface

// File: rtl/sound_arbiter.sv
// Shares one tone generator between the live colour tone and four prioritised event jingles.
// Optional SND_MUTE_EN adds a mute input that gates tone_ena after the output register.
module sound_arbiter #(
  parameter int TICK_DIV   = 1000,
  parameter int NOTE_TICKS = 8,
  parameter int GAP_TICKS  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  sound_arbiter_if.slave      bus,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {IDLE, COLOR, NOTE, GAP} state_t;

  localparam int MAX_TICKS = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int CW        = $clog2(TICK_DIV * MAX_TICKS + 1);
  localparam int NOTE_CYC  = TICK_DIV * NOTE_TICKS;
  localparam int GAP_CYC   = TICK_DIV * GAP_TICKS;
  localparam logic [CW-1:0] NOTE_LOAD = CW'(NOTE_CYC - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  // Jingle ids double as pending-bit indices; lower index wins.
  localparam logic [1:0] J_LOSE = 2'd0, J_WIN = 2'd1, J_HS = 2'd2, J_START = 2'd3;

  state_t        state_q, state_n;
  logic [3:0]    pend_q, pend_n, set_bits, clr_bits;
  logic          start_q;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [2:0]    idx_q, idx_n;
  logic [1:0]    jin_q, jin_n, sel;
  logic [2:0]    tone_q, tone_n;
  logic          ena_q, ena_n;
  logic          busy_q, busy_n;
  logic          step, take;

  function automatic logic [2:0] note_of(input logic [1:0] j, input logic [2:0] i);
    case (j)
      J_LOSE:  note_of = 3'd4;
      J_WIN:   note_of = (i == 3'd4) ? 3'd5 : i;
      J_HS:    note_of = (i == 3'd1) ? 3'd3 : 3'd5;
      default: note_of = i;
    endcase
  endfunction

  function automatic logic [2:0] last_idx(input logic [1:0] j);
    case (j)
      J_LOSE:  last_idx = 3'd1;
      J_WIN:   last_idx = 3'd4;
      J_HS:    last_idx = 3'd2;
      default: last_idx = 3'd3;
    endcase
  endfunction

  assign set_bits = {bus.start_req & ~start_q, bus.hs_pulse, bus.win_pulse, bus.lose_pulse};

  always_comb begin
    state_n  = state_q;
    tone_n   = tone_q;
    ena_n    = ena_q;
    cnt_n    = cnt_q;
    idx_n    = idx_q;
    jin_n    = jin_q;
    clr_bits = 4'b0000;
    step     = 1'b0;
    take     = 1'b0;
    sel      = J_START;

    case (state_q)
      IDLE: begin
        if (|pend_q) take = 1'b1;
        else if (bus.color_req) begin
          state_n = COLOR;
          tone_n  = {1'b0, bus.color};
          ena_n   = 1'b1;
        end
      end
      COLOR: begin
        if (|pend_q) take = 1'b1;
        else if (bus.color_req) tone_n = {1'b0, bus.color};
        else begin
          state_n = IDLE;
          ena_n   = 1'b0;
        end
      end
      NOTE: begin
        if (cnt_q == '0) begin
          if (GAP_TICKS > 0) begin
            state_n = GAP;
            ena_n   = 1'b0;
            cnt_n   = GAP_LOAD;
          end else step = 1'b1;
        end else cnt_n = cnt_q - CNT_ONE;
      end
      default: begin
        if (cnt_q == '0) step = 1'b1;
        else cnt_n = cnt_q - CNT_ONE;
      end
    endcase

    // End of a note or gap: advance within the jingle, then pending work, then colour.
    if (step) begin
      if (idx_q != last_idx(jin_q)) begin
        state_n = NOTE;
        idx_n   = idx_q + 3'd1;
        tone_n  = note_of(jin_q, idx_q + 3'd1);
        ena_n   = 1'b1;
        cnt_n   = NOTE_LOAD;
      end else if (|pend_q) take = 1'b1;
      else if (bus.color_req) begin
        state_n = COLOR;
        tone_n  = {1'b0, bus.color};
        ena_n   = 1'b1;
      end else begin
        state_n = IDLE;
        ena_n   = 1'b0;
      end
    end

    if (take) begin
      if (pend_q[0])      sel = J_LOSE;
      else if (pend_q[1]) sel = J_WIN;
      else if (pend_q[2]) sel = J_HS;
      else                sel = J_START;
      clr_bits = 4'b0001 << sel;
      state_n  = NOTE;
      jin_n    = sel;
      idx_n    = 3'd0;
      tone_n   = note_of(sel, 3'd0);
      ena_n    = 1'b1;
      cnt_n    = NOTE_LOAD;
    end

    // A request landing on the edge its bit is consumed survives, so it replays.
    pend_n = (pend_q & ~clr_bits) | set_bits;
    busy_n = (state_n == NOTE) || (state_n == GAP) || (|pend_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= 4'b0000;
      start_q <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      jin_q   <= J_LOSE;
      tone_q  <= 3'd0;
      ena_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      pend_q  <= pend_n;
      start_q <= bus.start_req;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      jin_q   <= jin_n;
      tone_q  <= tone_n;
      ena_q   <= ena_n;
      busy_q  <= busy_n;
    end
  end

  assign bus.tone  = tone_q;
  assign bus.busy  = busy_q;
  assign state_dbg = state_q;
`ifdef SND_MUTE_EN
  assign bus.tone_ena = ena_q & ~bus.mute;
`else
  assign bus.tone_ena = ena_q;
`endif

endmodule

// File: tb/tb_sound_arbiter.sv
// Bench for sound_arbiter at TICK_DIV=4, NOTE_TICKS=2, GAP_TICKS=1 (note 8 cycles, gap 4).
// Enabled-tone segments and busy runs are scored against expected queues by a negedge monitor.
module tb_sound_arbiter;
  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;
  int         checks = 0;
  int         passes = 0;

  logic [10:0] exp_q[$];   // {tone[2:0], length[7:0]} of each enabled-tone segment
  logic [7:0]  busy_q[$];  // length of each busy-high run

  sound_arbiter_if bus();

  sound_arbiter #(.TICK_DIV(4), .NOTE_TICKS(2), .GAP_TICKS(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- check helpers ----------------
  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  task automatic push_seg(input int tone, input int len);
    exp_q.push_back({3'(tone), 8'(len)});
  endtask

  // ---------------- monitor / scoreboard ----------------
  int         seg_len = 0;
  int         busy_len = 0;
  logic       ena_prev = 1'b0;
  logic       busy_prev = 1'b0;
  logic [2:0] tone_prev = 3'd0;

  task automatic close_seg(input logic [2:0] tone, input int len);
    logic [10:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL seg_unexpected: got tone=%0d len=%0d expected no segment", tone, len);
    end else begin
      e = exp_q.pop_front();
      if (e == {tone, 8'(len)}) passes++;
      else $display("FAIL note_seg: got tone=%0d len=%0d expected tone=%0d len=%0d",
                    tone, len, e[10:8], e[7:0]);
    end
  endtask

  task automatic close_busy(input int len);
    logic [7:0] e;
    checks++;
    if (busy_q.size() == 0) begin
      $display("FAIL busy_unexpected: got busy run %0d expected none", len);
    end else begin
      e = busy_q.pop_front();
      if (e == 8'(len)) passes++;
      else $display("FAIL busy_run: got %0d cycles expected %0d", len, e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      ena_prev  = 1'b0;
      busy_prev = 1'b0;
      seg_len   = 0;
      busy_len  = 0;
    end else begin
      if (bus.tone_ena) begin
        if (ena_prev && bus.tone == tone_prev) seg_len++;
        else begin
          if (ena_prev) close_seg(tone_prev, seg_len);
          seg_len = 1;
        end
      end else if (ena_prev) close_seg(tone_prev, seg_len);
      ena_prev  = bus.tone_ena;
      tone_prev = bus.tone;
      if (bus.busy) busy_len++;
      else if (busy_prev) close_busy(busy_len);
      if (!bus.busy) busy_len = 0;
      busy_prev = bus.busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse(input int kind);
    @(posedge clk); #1;
    case (kind)
      0: bus.lose_pulse = 1'b1;
      1: bus.win_pulse  = 1'b1;
      2: bus.hs_pulse   = 1'b1;
      default: begin bus.lose_pulse = 1'b1; bus.hs_pulse = 1'b1; end
    endcase
    @(posedge clk); #1;
    bus.lose_pulse = 1'b0;
    bus.win_pulse  = 1'b0;
    bus.hs_pulse   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!bus.busy && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) check({name, "_busy_rise"}, 0, 1);
    n = 0;
    while (bus.busy && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) check({name, "_busy_fall"}, 1, 0);
  endtask

  // ---------------- stimulus ----------------
  int busy_seen;
`ifdef SND_MUTE_EN
  logic [2:0] win_notes [5];
`endif

  initial begin
    rst_n          = 1'b0;
    bus.color_req  = 1'b1;
    bus.color      = 2'd3;
    bus.start_req  = 1'b1;
    bus.win_pulse  = 1'b1;
    bus.lose_pulse = 1'b1;
    bus.hs_pulse   = 1'b1;
`ifdef SND_MUTE_EN
    bus.mute       = 1'b0;
`endif

    // 1. Reset with every request active; start jingle plays after release.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_tone", int'(bus.tone), 0);
      check("reset_ena", int'(bus.tone_ena), 0);
      check("reset_busy", int'(bus.busy), 0);
    end
    for (int i = 0; i < 4; i++) push_seg(i, 8);
    busy_q.push_back(8'd49);
    @(posedge clk); #1;
    rst_n          = 1'b1;
    bus.color_req  = 1'b0;
    bus.win_pulse  = 1'b0;
    bus.lose_pulse = 1'b0;
    bus.hs_pulse   = 1'b0;
    wait_idle("start");
    bus.start_req = 1'b0;
    repeat (3) @(negedge clk);

    // 2. Colour tone 2 for 10 cycles, busy stays low.
    push_seg(2, 10);
    busy_seen = 0;
    @(posedge clk); #1;
    bus.color_req = 1'b1;
    bus.color     = 2'd2;
    repeat (10) begin @(posedge clk); #1; busy_seen |= int'(bus.busy); end
    bus.color_req = 1'b0;
    repeat (3) begin @(negedge clk); busy_seen |= int'(bus.busy); end
    check("color_busy_low", busy_seen, 0);

    // 3. Lose jingle: two buzz notes, 2-cycle start latency, 25 busy cycles.
    push_seg(4, 8);
    push_seg(4, 8);
    busy_q.push_back(8'd25);
    pulse(0);
    @(negedge clk);
    check("lose_lat_ena_low", int'(bus.tone_ena), 0);
    check("lose_lat_busy", int'(bus.busy), 1);
    @(negedge clk);
    check("lose_lat_ena_high", int'(bus.tone_ena), 1);
    wait_idle("lose");
    repeat (3) @(negedge clk);

    // 4. Simultaneous lose and high score: lose first, busy continuous.
    push_seg(4, 8); push_seg(4, 8);
    push_seg(5, 8); push_seg(3, 8); push_seg(5, 8);
    busy_q.push_back(8'd61);
    pulse(3);
    wait_idle("lose_hs");
    repeat (3) @(negedge clk);

    // 4b. Lose requested twice more during its own jingle: replays exactly once.
    for (int i = 0; i < 4; i++) push_seg(4, 8);
    busy_q.push_back(8'd49);
    pulse(0);
    repeat (2) @(posedge clk);
    pulse(0);
    repeat (9) @(posedge clk);
    pulse(0);
    wait_idle("lose_replay");
    repeat (3) @(negedge clk);

    // 5. Win cuts colour tone 1, colour resumes after the last gap.
    push_seg(1, 5);
    push_seg(0, 8); push_seg(1, 8); push_seg(2, 8); push_seg(3, 8); push_seg(5, 8);
    push_seg(1, 6);
    busy_q.push_back(8'd61);
    @(posedge clk); #1;
    bus.color_req = 1'b1;
    bus.color     = 2'd1;
    repeat (3) @(posedge clk);
    pulse(1);
    wait_idle("win_color");
    repeat (5) @(posedge clk);
    #1 bus.color_req = 1'b0;
    repeat (3) @(negedge clk);

    // 7. Asynchronous reset in the middle of a jingle clears everything at once.
    pulse(2);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midreset_tone", int'(bus.tone), 0);
    check("midreset_ena", int'(bus.tone_ena), 0);
    check("midreset_busy", int'(bus.busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    busy_seen = 0;
    repeat (6) begin @(negedge clk); busy_seen |= int'(bus.busy) | int'(bus.tone_ena); end
    check("midreset_quiet", busy_seen, 0);

`ifdef SND_MUTE_EN
    // 6. Muted win jingle: notes still step, enable held low, busy timing unchanged.
    win_notes[0] = 3'd0; win_notes[1] = 3'd1; win_notes[2] = 3'd2;
    win_notes[3] = 3'd3; win_notes[4] = 3'd5;
    busy_q.push_back(8'd61);
    bus.mute = 1'b1;
    pulse(1);
    @(negedge clk);
    repeat (5) @(negedge clk);
    for (int n = 0; n < 5; n++) begin
      check("mute_tone", int'(bus.tone), int'(win_notes[n]));
      check("mute_ena", int'(bus.tone_ena), 0);
      if (n < 4) repeat (12) @(negedge clk);
    end
    wait_idle("mute_win");
    bus.mute = 1'b0;
    repeat (3) @(negedge clk);
`endif

    repeat (5) @(negedge clk);
    check("seg_queue_empty", exp_q.size(), 0);
    check("busy_queue_empty", busy_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
